// File: rtl/ddr_wr_arbiter.sv
// ddr_wr_arbiter: shares one AXI write port to DDR between CH_NUM sampler
// channels. Round-robin grant (fixed priority with DDR_ARB_FIXED_PRIO_EN).
// Ports:
//   clk, rst                  : DDR-side clock, async active-high reset
//   ch_ready/ch_frame_start   : per-channel burst available / frame start
//   ch_rd_data/ch_rd_en       : per-channel FIFO head word / pop
//   axi_aw*, axi_w*, axi_b*   : AXI write address, data, response channels
//   trans_id                  : granted channel + 1 while a burst is active
module ddr_wr_arbiter #(
  parameter int CH_NUM = 4,
  parameter int DQ_WIDTH = 32,
  parameter int BURST_LEN = 16,
  parameter int ADDR_WIDTH = 28,
  parameter logic [ADDR_WIDTH-1:0] FRAME_STRIDE = 'h080_0000,
  parameter int FRAME_BURSTS = 1800
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CH_NUM-1:0]            ch_ready,
  input  logic [CH_NUM-1:0]            ch_frame_start,
  input  logic [CH_NUM*DQ_WIDTH*8-1:0] ch_rd_data,
  output logic [CH_NUM-1:0]            ch_rd_en,
  output logic [ADDR_WIDTH-1:0]        axi_awaddr,
  output logic [7:0]                   axi_awlen,
  output logic                         axi_awvalid,
  input  logic                         axi_awready,
  output logic [DQ_WIDTH*8-1:0]        axi_wdata,
  output logic                         axi_wvalid,
  input  logic                         axi_wready,
  output logic                         axi_wlast,
  input  logic                         axi_bvalid,
  output logic                         axi_bready,
  output logic [3:0]                   trans_id
);

  localparam int BW = DQ_WIDTH * 8;
  localparam int SW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES =
    ADDR_WIDTH'(BURST_LEN * DQ_WIDTH);
  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);
  localparam logic [10:0] WPTR_MAX = 11'(FRAME_BURSTS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]        state;
  logic [SW-1:0]     sel;
  logic [SW-1:0]     gnt;
  logic [7:0]        beat;
  logic [10:0]       wptr [CH_NUM];
  logic [CH_NUM-1:0] pend;
  logic              busy;
  logic              done;
  logic              w_hs;

  assign busy = (state != IDLE);
  assign done = (state == RESP) && axi_bvalid;
  assign w_hs = axi_wvalid && axi_wready;

`ifdef DDR_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (ch_ready[i]) gnt = SW'(i);
    end
  end
`else
  logic [SW-1:0] last;
  logic [SW-1:0] hi;
  logic [SW-1:0] lo;
  logic          hi_v;

  // lo: lowest ready overall; hi: lowest ready above last.
  // Taking hi when present gives the upward search with wrap.
  always_comb begin
    hi   = '0;
    lo   = '0;
    hi_v = 1'b0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (ch_ready[i]) begin
        lo = SW'(i);
        if (i > int'(last)) begin
          hi   = SW'(i);
          hi_v = 1'b1;
        end
      end
    end
    gnt = hi_v ? hi : lo;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= '0;
      beat     <= '0;
      trans_id <= '0;
`ifndef DDR_ARB_FIXED_PRIO_EN
      last     <= SW'(CH_NUM - 1);
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (|ch_ready) begin
            sel      <= gnt;
            trans_id <= 4'(gnt) + 4'd1;
            state    <= ADDR;
          end
        end
        ADDR: begin
          if (axi_awready) begin
            beat  <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          if (axi_wready) begin
            beat <= beat + 8'd1;
            if (beat == LAST_BEAT) state <= RESP;
          end
        end
        RESP: begin
          if (axi_bvalid) begin
            trans_id <= '0;
            state    <= IDLE;
`ifndef DDR_ARB_FIXED_PRIO_EN
            last     <= sel;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A frame start on the granted channel is deferred so the
  // address of the burst in flight stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH_NUM; i++) wptr[i] <= '0;
      pend <= '0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (done && sel == SW'(i)) begin
          if (pend[i] || ch_frame_start[i] || wptr[i] == WPTR_MAX)
            wptr[i] <= '0;
          else
            wptr[i] <= wptr[i] + 11'd1;
          pend[i] <= 1'b0;
        end else if (ch_frame_start[i]) begin
          if (busy && sel == SW'(i)) pend[i] <= 1'b1;
          else wptr[i] <= '0;
        end
      end
    end
  end

  assign axi_awvalid = (state == ADDR);
  assign axi_wvalid  = (state == DATA);
  assign axi_bready  = (state == RESP);
  assign axi_awlen   = LAST_BEAT;
  assign axi_wlast   = axi_wvalid && (beat == LAST_BEAT);

  always_comb begin
    axi_awaddr = '0;
    if (state == ADDR) begin
      axi_awaddr = ADDR_WIDTH'(sel) * FRAME_STRIDE
                 + ADDR_WIDTH'(wptr[sel]) * BURST_BYTES;
    end
  end

  always_comb begin
    axi_wdata = '0;
    ch_rd_en  = '0;
    if (axi_wvalid) axi_wdata = ch_rd_data[int'(sel)*BW +: BW];
    if (w_hs) ch_rd_en = CH_NUM'(1) << sel;
  end

endmodule

// File: tb/tb_ddr_wr_arbiter.sv
// tb_ddr_wr_arbiter: randomized scoreboard bench for ddr_wr_arbiter.
// Reference model predicts grant, address and beat data per burst.
module tb_ddr_wr_arbiter;

  localparam int CH = 4;
  localparam int DQ = 32;
  localparam int BL = 16;
  localparam int AW = 28;
  localparam int FB = 4;
  localparam int BW = DQ * 8;
  localparam logic [AW-1:0] STRIDE = 28'h080_0000;

  logic              clk;
  logic              rst;
  logic [CH-1:0]     ch_ready;
  logic [CH-1:0]     ch_frame_start;
  logic [CH*BW-1:0]  ch_rd_data;
  logic [CH-1:0]     ch_rd_en;
  logic [AW-1:0]     axi_awaddr;
  logic [7:0]        axi_awlen;
  logic              axi_awvalid;
  logic              axi_awready;
  logic [BW-1:0]     axi_wdata;
  logic              axi_wvalid;
  logic              axi_wready;
  logic              axi_wlast;
  logic              axi_bvalid;
  logic              axi_bready;
  logic [3:0]        trans_id;

  ddr_wr_arbiter #(
    .CH_NUM(CH), .DQ_WIDTH(DQ), .BURST_LEN(BL), .ADDR_WIDTH(AW),
    .FRAME_STRIDE(STRIDE), .FRAME_BURSTS(FB)
  ) dut (
    .clk(clk), .rst(rst), .ch_ready(ch_ready),
    .ch_frame_start(ch_frame_start), .ch_rd_data(ch_rd_data),
    .ch_rd_en(ch_rd_en), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready), .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .trans_id(trans_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [BW-1:0] make_word(input int ch, input int n);
    return {8{8'(ch), 16'(n), 8'hA5}};
  endfunction

  // Pre-read FIFO environment: head word advances on every pop.
  int env_pop [CH];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) env_pop[i] <= 0;
    end else begin
      for (int i = 0; i < CH; i++)
        if (ch_rd_en[i]) env_pop[i] <= env_pop[i] + 1;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_fifo
    assign ch_rd_data[g*BW +: BW] = make_word(g, env_pop[g]);
  end

  // Reference model
  typedef struct {
    int            ch;
    logic [AW-1:0] addr;
  } aw_t;

  aw_t           exp_aw [$];
  logic [BW-1:0] exp_d [$];
  int            m_wptr [CH];
  bit            m_pend [CH];
  int            m_pop [CH];
  int            m_last;

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_wptr[i] = 0;
      m_pend[i] = 1'b0;
      m_pop[i]  = 0;
    end
    m_last = CH - 1;
    exp_aw.delete();
    exp_d.delete();
  endtask

  function automatic int model_grant(input logic [CH-1:0] mask);
`ifdef DDR_ARB_FIXED_PRIO_EN
    for (int i = 0; i < CH; i++) if (mask[i]) return i;
`else
    for (int k = 1; k <= CH; k++) begin
      int idx;
      idx = (m_last + k) % CH;
      if (mask[idx]) return idx;
    end
`endif
    return -1;
  endfunction

  task automatic chk(input string name, input logic [BW-1:0] act,
                     input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic push_burst(input int c);
    aw_t r;
    r.ch   = c;
    r.addr = AW'(c) * STRIDE + AW'(m_wptr[c] * BL * DQ);
    exp_aw.push_back(r);
    for (int n = 0; n < BL; n++) begin
      exp_d.push_back(make_word(c, m_pop[c]));
      m_pop[c]++;
    end
  endtask

  // Monitor: samples 2 time units after the falling edge.
  initial begin
    bit            have;
    int            cur;
    int            beat;
    bit            aw_p;
    bit            w_p;
    logic [AW-1:0] aw_a;
    logic [CH-1:0] exp_en;
    aw_t           r;
    have = 0; cur = 0; beat = 0; aw_p = 0; w_p = 0; aw_a = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        have = 0; beat = 0; aw_p = 0; w_p = 0;
        continue;
      end
      exp_en = (axi_wvalid && axi_wready && have) ? CH'(1) << cur : '0;
      chk("rd_en", ch_rd_en, exp_en);
      if (aw_p) chk("aw_hold", {axi_awvalid, axi_awaddr}, {1'b1, aw_a});
      if (axi_awvalid && axi_awready) begin
        if (exp_aw.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL aw_unexpected actual=%0h required=none",
                   axi_awaddr);
        end else begin
          r = exp_aw.pop_front();
          chk("awaddr", axi_awaddr, r.addr);
          chk("awlen", axi_awlen, 8'(BL - 1));
          chk("trans_id", trans_id, 4'(r.ch + 1));
          cur = r.ch; have = 1; beat = 0;
        end
      end
      aw_p = axi_awvalid && !axi_awready;
      aw_a = axi_awaddr;
      if (w_p) chk("w_hold", axi_wvalid, 1'b1);
      if (axi_wvalid && axi_wready) begin
        if (exp_d.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL w_unexpected actual=%0h required=none",
                   axi_wdata);
        end else begin
          chk("wdata", axi_wdata, exp_d.pop_front());
        end
        chk("wlast", axi_wlast, beat == BL - 1);
        beat++;
      end
      w_p = axi_wvalid && !axi_wready;
    end
  end

  // mode 0: all ready; 1: random handshakes and ch_ready noise;
  // 2: awready low 5 cycles then wready toggling.
  task automatic run_burst(input logic [CH-1:0] mask, input int mode,
                           input bit fs_en, input int fs_ch,
                           input int fs_at);
    int c;
    int cyc;
    int aw_n;
    bit wt;
    bit fs_done;
    c = model_grant(mask);
    push_burst(c);
    @(negedge clk);
    ch_ready   = mask;
    axi_bvalid = 1'b0;
    @(negedge clk);
    chk("aw_latency", axi_awvalid, 1'b1);
    ch_ready = '0;
    cyc = 0; aw_n = 0; wt = 1'b0; fs_done = 1'b0;
    while (trans_id != 4'd0 && cyc < 600) begin
      case (mode)
        0: begin
          axi_awready = 1'b1;
          axi_wready  = 1'b1;
          axi_bvalid  = axi_bready;
        end
        1: begin
          axi_awready = 1'($urandom);
          axi_wready  = 1'($urandom);
          axi_bvalid  = axi_bready & 1'($urandom);
          ch_ready    = CH'($urandom);
        end
        default: begin
          axi_awready = !(axi_awvalid && aw_n < 5);
          if (axi_awvalid) aw_n++;
          wt = !wt;
          axi_wready = wt;
          axi_bvalid = axi_bready;
        end
      endcase
      ch_frame_start = '0;
      if (fs_en && !fs_done && cyc == fs_at) begin
        ch_frame_start[fs_ch] = 1'b1;
        fs_done = 1'b1;
        if (fs_ch == c) m_pend[c] = 1'b1;
        else m_wptr[fs_ch] = 0;
      end
      @(negedge clk);
      cyc++;
    end
    ch_frame_start = '0;
    ch_ready       = '0;
    axi_bvalid     = 1'b0;
    if (cyc >= 600) begin
      checks++;
      errors++;
      $display("FAIL burst_timeout actual=%0d required=<600", cyc);
    end
    m_wptr[c] = m_pend[c] ? 0 : (m_wptr[c] + 1) % FB;
    m_pend[c] = 1'b0;
    m_last    = c;
  endtask

  task automatic reset_mid_data();
    int c;
    int pops;
    int cyc;
    c = model_grant(CH'(1));
    push_burst(c);
    @(negedge clk);
    ch_ready = CH'(1);
    @(negedge clk);
    ch_ready    = '0;
    axi_awready = 1'b1;
    axi_wready  = 1'b1;
    pops = 0; cyc = 0;
    while (pops < 8 && cyc < 200) begin
      if (axi_wvalid && axi_wready) pops++;
      @(negedge clk);
      cyc++;
    end
    chk("pops_before_rst", 32'(pops), 32'd8);
    rst = 1'b1;
    #1;
    chk("rst_outputs",
        {axi_awvalid, axi_wvalid, axi_wlast, axi_bready,
         axi_awaddr, trans_id, ch_rd_en}, '0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ch_ready = '0;
    ch_frame_start = '0;
    axi_awready = 1'b0;
    axi_wready = 1'b0;
    axi_bvalid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs",
        {axi_awvalid, axi_wvalid, axi_wlast, axi_bready,
         axi_awaddr, trans_id, ch_rd_en}, '0);

    for (int i = 0; i < 5; i++) run_burst(4'b1111, 0, 0, 0, 0);
    run_burst(4'b0100, 0, 0, 0, 0);
    run_burst(4'b0010, 2, 0, 0, 0);
    run_burst(4'b0010, 0, 1, 1, 6);
    run_burst(4'b0010, 0, 0, 0, 0);
    for (int i = 0; i < FB + 1; i++) run_burst(4'b0001, 0, 0, 0, 0);
    reset_mid_data();
    run_burst(4'b1111, 0, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [CH-1:0] m;
      m = CH'($urandom_range(15, 1));
      run_burst(m, int'($urandom_range(2, 0)),
                ($urandom_range(3, 0) == 0),
                int'($urandom_range(CH - 1, 0)),
                int'($urandom_range(20, 0)));
    end

    repeat (3) @(negedge clk);
    chk("aw_queue_empty", 32'(exp_aw.size()), 32'd0);
    chk("w_queue_empty", 32'(exp_d.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_wr_arbiter.md
# ddr_wr_arbiter

Round-robin write scheduler that shares one AXI write port to DDR between `CH_NUM` video sampling channels. Each channel has a burst-buffer FIFO that raises `data_out_ready` once a full burst is stored. The arbiter picks one ready channel and issues an AXI write burst of `BURST_LEN` beats. It pops that channel's FIFO beat by beat and keeps a per-channel frame write pointer inside a fixed DDR region. It sits between the sampler instances and the DDR controller, on the DDR-side clock.

## Interface
Parameters:
- `CH_NUM`, 4: number of sampler channels (2..8).
- `DQ_WIDTH`, 32: DDR DQ width; beat width is `DQ_WIDTH*8`.
- `BURST_LEN`, 16: beats per burst (1..256).
- `ADDR_WIDTH`, 28: AXI address width, in bytes.
- `FRAME_STRIDE`, 28'h080_0000: byte distance between channel regions.
- `FRAME_BURSTS`, 1800: bursts per frame before the pointer wraps.

Ports:
- `clk` in 1: DDR-side clock.
- `rst` in 1: reset, asynchronous, active-high.
- `ch_ready` in `CH_NUM`: per-channel burst available (sampler `data_out_ready`).
- `ch_frame_start` in `CH_NUM`: one-cycle pulse per channel at frame start, already synchronised to `clk`.
- `ch_rd_data` in `CH_NUM*DQ_WIDTH*8`: per-channel FIFO head word. Channel i occupies slice i. The word is valid before pop (pre-read FIFO).
- `ch_rd_en` out `CH_NUM`: per-channel FIFO pop.
- `axi_awaddr` out `ADDR_WIDTH`: burst byte address.
- `axi_awlen` out 8: constant `BURST_LEN-1`.
- `axi_awvalid` out 1 / `axi_awready` in 1: write address handshake.
- `axi_wdata` out `DQ_WIDTH*8`: write data beat.
- `axi_wvalid` out 1 / `axi_wready` in 1: write data handshake.
- `axi_wlast` out 1: marks the final beat of the burst.
- `axi_bvalid` in 1 / `axi_bready` out 1: write response handshake.
- `trans_id` out 4: channel index + 1 while a burst is active, 0 otherwise.

## Operation
- FSM states: IDLE → ADDR → DATA → RESP → IDLE.
- **IDLE**
  - When any `ch_ready` bit is set, register the grant `sel` and go to ADDR.
  - Grant rule: the first set bit searching upward from `last+1`, wrapping modulo `CH_NUM`.
  - After reset `last = CH_NUM-1`, so channel 0 has first priority.
- **ADDR**
  - `axi_awvalid`=1 and `axi_awaddr = sel*FRAME_STRIDE + wptr[sel]*BURST_LEN*DQ_WIDTH`.
  - When `axi_awvalid & axi_awready`, go to DATA.
- **DATA**
  - `axi_wvalid`=1 and `axi_wdata = ch_rd_data[sel]` (combinational mux).
  - `ch_rd_en[sel] = axi_wvalid & axi_wready`; all other `ch_rd_en` bits are 0.
  - Beat counter increments on each handshake.
  - `axi_wlast` = (beat counter == `BURST_LEN-1`).
  - The handshake on the last beat moves the FSM to RESP.
- **RESP**
  - `axi_bready`=1.
  - On `axi_bvalid`: `last<=sel`, `wptr[sel]` advances, return to IDLE.
- Write pointers, one 11-bit `wptr` per channel:
  - `wptr` wraps to 0 when it reaches `FRAME_BURSTS`.
  - `ch_frame_start[i]` clears `wptr[i]` immediately if channel i is not the current grant.
  - If channel i is the current grant (ADDR/DATA/RESP), the clear is latched in `pend[i]`. At burst completion `wptr[i]` becomes 0 (clear wins over increment) and `pend[i]` is cleared.
- `ch_ready` is sampled only in IDLE; changes during a burst are ignored.

## Timing
- Reset values: `ch_rd_en`=0, `axi_awvalid`=0, `axi_wvalid`=0, `axi_wlast`=0, `axi_bready`=0, `axi_awaddr`=0, `trans_id`=0, all `wptr`=0, all `pend`=0, FSM in IDLE.
- `rst` asserted mid-burst returns the block to the reset state immediately; the AXI transaction is abandoned.
- Latency:
  - `ch_ready` seen in IDLE → `axi_awvalid` high on the next cycle.
  - No wait states are inserted between beats when `axi_wready` is held at 1.
  - A minimum burst takes `BURST_LEN + 3` cycles, plus the AXI response delay.
- `axi_awvalid` and `axi_wvalid` stay high until their handshake completes (AXI rule). `axi_awaddr` is stable while `axi_awvalid` is high.
- `trans_id` is registered: it equals `sel+1` from ADDR entry until RESP exit.

## Configuration
- `DDR_ARB_FIXED_PRIO_EN` defined: fixed priority; the lowest-index ready channel always wins and `last` is unused.
- Undefined (default): round robin as described above.

## Test plan
- Single-channel burst: `CH_NUM`=4, `BURST_LEN`=16, `ch_ready`=4'b0100, `axi_wready`=1.
  - Expect `awaddr` = 2*`FRAME_STRIDE`, `awlen`=15, `trans_id`=3.
  - Expect 16 `ch_rd_en[2]` pulses, `wlast` on the 16th, and `wptr[2]`=1 after `bvalid`.
- Fairness: `ch_ready`=4'b1111 held.
  - Default build: grants in order 0,1,2,3,0.
  - With `DDR_ARB_FIXED_PRIO_EN`: grants 0,0,0.
- Backpressure: `awready` low for 5 cycles, `wready` toggled 1/0.
  - `awvalid`/`awaddr` stay stable.
  - Exactly 16 pops, each aligned to a `wvalid&wready` handshake.
  - `wdata` follows `ch_rd_data[sel]`.
- Frame start mid-burst on the granted channel 1 with `wptr[1]`=7: after `bvalid`, `wptr[1]`=0, and the next burst address is 1*`FRAME_STRIDE`.
- Wrap: `FRAME_BURSTS`=4, channel 0 issues 5 bursts. The 5th `awaddr` equals the 1st.
- Reset mid-DATA at beat 8: all outputs are 0 in the same cycle, and the FSM restarts from IDLE with channel 0 priority.
